prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 188 ++++++++++++++++++
 tb/tb_prog_loader.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Streams a program into the PCPU instruction memory and then releases the
// CPU. A load_req pulse opens a stream window; every accepted beat becomes one
// instruction-memory write one cycle later, at the next ascending address.
// Once the stream ends (s_last) the rest of memory is optionally cleared to
// 16'h0000, after which the CPU is started and enabled. A load_req while the
// CPU runs stops it and starts a fresh load from address 0.
//
// Parameters
//   FILL_ZERO  1: zero-fill the words the stream did not write before RUN
//   ADDR_W     instruction-memory address width (depth 2**ADDR_W)
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous, active-low reset
//   load_req    single-cycle pulse starting a program load
//   s_valid     stream beat valid
//   s_data      stream instruction word
//   s_last      final beat of the program
//   s_ready     loader accepts a beat this cycle (registered)
//   i_we        instruction-memory write strobe (registered)
//   i_addr      instruction-memory write address (registered)
//   i_data      instruction-memory write data (registered)
//   cpu_start   PCPU start (registered)
//   cpu_enable  PCPU enable (registered)
//   word_count  beats accepted in the current load, 0..2**ADDR_W
//   overflow    sticky: memory filled before s_last arrived
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int FILL_ZERO = 1,
    parameter int ADDR_W    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_req,
    input  logic              s_valid,
    input  logic [15:0]       s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              i_we,
    output logic [ADDR_W-1:0] i_addr,
    output logic [15:0]       i_data,
    output logic              cpu_start,
    output logic              cpu_enable,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CLEAR = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   WC_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;        // next address to be written
    logic              s_ready_reg;
    logic              i_we_reg;
    logic [ADDR_W-1:0] i_addr_reg;
    logic [15:0]       i_data_reg;
    logic              cpu_start_reg;
    logic              cpu_enable_reg;
    logic [ADDR_W:0]   word_count_reg;
    logic              overflow_reg;

    // A beat is taken only against the registered ready, so the handshake
    // never forms a combinational path from the stream to any output.
    logic beat_ok;
    logic at_max;

    assign beat_ok = s_valid && s_ready_reg;
    assign at_max  = (addr_reg == ADDR_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            s_ready_reg    <= 1'b0;
            i_we_reg       <= 1'b0;
            i_addr_reg     <= '0;
            i_data_reg     <= '0;
            cpu_start_reg  <= 1'b0;
            cpu_enable_reg <= 1'b0;
            word_count_reg <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            // The write strobe is a one-cycle pulse unless a state below
            // issues a write this cycle.
            i_we_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    s_ready_reg    <= 1'b0;
                    cpu_start_reg  <= 1'b0;
                    cpu_enable_reg <= 1'b0;
                    if (load_req) begin
                        state_reg      <= LOAD;
                        s_ready_reg    <= 1'b1;
                        addr_reg       <= '0;
                        word_count_reg <= '0;
                        overflow_reg   <= 1'b0;
                    end
                end

                LOAD: begin
                    // load_req is deliberately not looked at here.
                    if (beat_ok) begin
                        i_we_reg       <= 1'b1;
                        i_addr_reg     <= addr_reg;
                        i_data_reg     <= s_data;
                        word_count_reg <= word_count_reg + WC_ONE;
                        if (at_max) begin
                            // Memory is full: stop here, never wrap to 0.
                            state_reg   <= RUN;
                            s_ready_reg <= 1'b0;
                            if (!s_last) begin
                                overflow_reg <= 1'b1;
                            end
                        end else begin
                            addr_reg <= addr_reg + ADDR_ONE;
                            if (s_last) begin
                                s_ready_reg <= 1'b0;
                                if (FILL_ZERO != 0) begin
                                    state_reg <= CLEAR;
                                end else begin
                                    state_reg <= RUN;
                                end
                            end
                        end
                    end
                end

                CLEAR: begin
                    // Back-to-back zero writes straight after the last data
                    // write, ending with the top address inclusive.
                    i_we_reg   <= 1'b1;
                    i_addr_reg <= addr_reg;
                    i_data_reg <= '0;
                    if (at_max) begin
                        state_reg <= RUN;
                    end else begin
                        addr_reg <= addr_reg + ADDR_ONE;
                    end
                end

                RUN: begin
                    // The final memory write is issued on the edge that
                    // enters RUN, so the CPU sees its start one cycle after
                    // the last word has landed.
                    if (load_req) begin
                        state_reg      <= LOAD;
                        s_ready_reg    <= 1'b1;
                        cpu_start_reg  <= 1'b0;
                        cpu_enable_reg <= 1'b0;
                        addr_reg       <= '0;
                        word_count_reg <= '0;
                        overflow_reg   <= 1'b0;
                    end else begin
                        s_ready_reg    <= 1'b0;
                        cpu_start_reg  <= 1'b1;
                        cpu_enable_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign s_ready    = s_ready_reg;
    assign i_we       = i_we_reg;
    assign i_addr     = i_addr_reg;
    assign i_data     = i_data_reg;
    assign cpu_start  = cpu_start_reg;
    assign cpu_enable = cpu_enable_reg;
    assign word_count = word_count_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Two loaders share one stream: dut0 zero-fills (FILL_ZERO=1), dut1 does not.
// Each DUT has its own load_req, so only the DUT currently loading reacts to
// the stream. Expected memory writes (address, data, cycle) are queued when
// stimulus is driven and popped by a per-DUT monitor on every i_we pulse.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    localparam int AW = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        int            cyc;
    } wr_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          load_req0, load_req1;
    logic          s_valid;
    logic [15:0]   s_data;
    logic          s_last;

    logic          s_ready0, i_we0, cpu_start0, cpu_enable0, overflow0;
    logic [AW-1:0] i_addr0;
    logic [15:0]   i_data0;
    logic [AW:0]   word_count0;

    logic          s_ready1, i_we1, cpu_start1, cpu_enable1, overflow1;
    logic [AW-1:0] i_addr1;
    logic [15:0]   i_data1;
    logic [AW:0]   word_count1;

    wr_t q0[$];
    wr_t q1[$];
    wr_t e0, e1;
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  wr_cnt0 = 0;
    int  wr_cnt1 = 0;
    int  exp_addr0 = 0;
    int  exp_addr1 = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    prog_loader #(.FILL_ZERO(1), .ADDR_W(AW)) dut0 (
        .clock(clock), .reset(reset), .load_req(load_req0),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready0), .i_we(i_we0), .i_addr(i_addr0), .i_data(i_data0),
        .cpu_start(cpu_start0), .cpu_enable(cpu_enable0),
        .word_count(word_count0), .overflow(overflow0)
    );

    prog_loader #(.FILL_ZERO(0), .ADDR_W(AW)) dut1 (
        .clock(clock), .reset(reset), .load_req(load_req1),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready1), .i_we(i_we1), .i_addr(i_addr1), .i_data(i_data1),
        .cpu_start(cpu_start1), .cpu_enable(cpu_enable1),
        .word_count(word_count1), .overflow(overflow1)
    );

    // Scoreboard monitors: one line per memory write.
    always @(negedge clock) begin
        if (i_we0) begin
            wr_cnt0++;
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL wr0_unexpected got addr=%0d data=%h cyc=%0d, required no write",
                         i_addr0, i_data0, cyc);
            end else begin
                e0 = q0.pop_front();
                if (i_addr0 !== e0.addr || i_data0 !== e0.data || cyc != e0.cyc) begin
                    errors++;
                    $display("FAIL wr0 got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                             i_addr0, i_data0, cyc, e0.addr, e0.data, e0.cyc);
                end else begin
                    $display("wr0 addr=%0d data=%h cyc=%0d ok", i_addr0, i_data0, cyc);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (i_we1) begin
            wr_cnt1++;
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL wr1_unexpected got addr=%0d data=%h cyc=%0d, required no write",
                         i_addr1, i_data1, cyc);
            end else begin
                e1 = q1.pop_front();
                if (i_addr1 !== e1.addr || i_data1 !== e1.data || cyc != e1.cyc) begin
                    errors++;
                    $display("FAIL wr1 got addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                             i_addr1, i_data1, cyc, e1.addr, e1.data, e1.cyc);
                end else begin
                    $display("wr1 addr=%0d data=%h cyc=%0d ok", i_addr1, i_data1, cyc);
                end
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_wr(input bit which, input int a, input logic [15:0] d, input int c);
        wr_t e;
        e.addr = a[AW-1:0];
        e.data = d;
        e.cyc  = c;
        if (which) q1.push_back(e);
        else       q0.push_back(e);
    endtask

    // Drive one beat for a cycle; it is accepted at the next edge and written
    // one cycle after that.
    task automatic beat(input bit which, input logic [15:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        if (which) begin
            exp_wr(1'b1, exp_addr1, d, cyc + 1);
            exp_addr1++;
        end else begin
            exp_wr(1'b0, exp_addr0, d, cyc + 1);
            exp_addr0++;
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic test_reset();
        logic [37:0] v0, v1;
        reset = 1'b1; load_req0 = 1'b0; load_req1 = 1'b0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        #1 reset = 1'b0;
        #2;
        v0 = {s_ready0, i_we0, i_addr0, i_data0, cpu_start0, cpu_enable0, word_count0, overflow0};
        v1 = {s_ready1, i_we1, i_addr1, i_data1, cpu_start1, cpu_enable1, word_count1, overflow1};
        checks++;
        if (v0 !== 38'd0) begin errors++; $display("FAIL reset_outs0 got %h, required 0", v0); end
        checks++;
        if (v1 !== 38'd0) begin errors++; $display("FAIL reset_outs1 got %h, required 0", v1); end
        repeat (3) tick();
        reset = 1'b1;
        // Stream activity without load_req must not start anything.
        s_valid = 1'b1; s_data = 16'hDEAD; s_last = 1'b1;
        repeat (4) tick();
        s_valid = 1'b0; s_last = 1'b0;
        v0 = {s_ready0, i_we0, i_addr0, i_data0, cpu_start0, cpu_enable0, word_count0, overflow0};
        v1 = {s_ready1, i_we1, i_addr1, i_data1, cpu_start1, cpu_enable1, word_count1, overflow1};
        checks++;
        if (v0 !== 38'd0) begin errors++; $display("FAIL idle_after_release0 got %h, required 0", v0); end
        checks++;
        if (v1 !== 38'd0) begin errors++; $display("FAIL idle_after_release1 got %h, required 0", v1); end
        $display("test_reset done");
    endtask

    task automatic test_fill();
        int c;
        load_req0 = 1'b1; tick(); load_req0 = 1'b0;
        exp_addr0 = 0;
        checks++;
        if (s_ready0 !== 1'b1) begin errors++; $display("FAIL fill_ready got %b, required 1", s_ready0); end
        beat(1'b0, 16'h1111, 1'b0);
        beat(1'b0, 16'h2222, 1'b0);
        c = cyc;
        beat(1'b0, 16'h3333, 1'b1);
        for (int a = 3; a <= 255; a++) exp_wr(1'b0, a, 16'h0000, c + 1 + (a - 2));
        while (cyc < c + 254) tick();
        checks++;
        if (cpu_start0 !== 1'b0) begin errors++; $display("FAIL fill_start_early got %b, required 0", cpu_start0); end
        tick();
        checks++;
        if (cpu_start0 !== 1'b1 || cpu_enable0 !== 1'b1) begin
            errors++; $display("FAIL fill_run got start=%b en=%b, required 1 1", cpu_start0, cpu_enable0);
        end
        checks++;
        if (word_count0 !== 9'd3) begin errors++; $display("FAIL fill_count got %0d, required 3", word_count0); end
        checks++;
        if (i_we0 !== 1'b0 || s_ready0 !== 1'b0 || overflow0 !== 1'b0) begin
            errors++; $display("FAIL fill_run_outs got we=%b rdy=%b ovf=%b, required 0 0 0", i_we0, s_ready0, overflow0);
        end
        checks++;
        if (q0.size() != 0) begin errors++; $display("FAIL fill_pending got %0d, required 0", q0.size()); end
        $display("test_fill done");
    endtask

    task automatic test_no_fill();
        int c, w0;
        load_req1 = 1'b1; tick(); load_req1 = 1'b0;
        exp_addr1 = 0;
        w0 = wr_cnt1;
        beat(1'b1, 16'h1111, 1'b0);
        beat(1'b1, 16'h2222, 1'b0);
        c = cyc;
        beat(1'b1, 16'h3333, 1'b1);
        checks++;
        if (i_we1 !== 1'b1 || cpu_start1 !== 1'b0) begin
            errors++; $display("FAIL nofill_last_wr got we=%b start=%b, required 1 0", i_we1, cpu_start1);
        end
        tick();
        checks++;
        if (cpu_start1 !== 1'b1 || cpu_enable1 !== 1'b1 || i_we1 !== 1'b0) begin
            errors++; $display("FAIL nofill_run got start=%b en=%b we=%b, required 1 1 0", cpu_start1, cpu_enable1, i_we1);
        end
        repeat (4) tick();
        checks++;
        if (wr_cnt1 - w0 != 3) begin errors++; $display("FAIL nofill_pulses got %0d, required 3", wr_cnt1 - w0); end
        checks++;
        if (word_count1 !== 9'd3) begin errors++; $display("FAIL nofill_count got %0d, required 3", word_count1); end
        $display("test_no_fill done (c=%0d)", c);
    endtask

    task automatic test_overflow();
        load_req0 = 1'b1; tick(); load_req0 = 1'b0;
        exp_addr0 = 0;
        checks++;
        if (cpu_start0 !== 1'b0) begin errors++; $display("FAIL ovf_stop got %b, required 0", cpu_start0); end
        for (int i = 0; i < 256; i++) beat(1'b0, 16'($urandom), 1'b0);
        checks++;
        if (overflow0 !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b, required 1", overflow0); end
        checks++;
        if (word_count0 !== 9'd256) begin errors++; $display("FAIL ovf_count got %0d, required 256", word_count0); end
        checks++;
        if (s_ready0 !== 1'b0) begin errors++; $display("FAIL ovf_ready got %b, required 0", s_ready0); end
        tick();
        checks++;
        if (cpu_start0 !== 1'b1) begin errors++; $display("FAIL ovf_run got %b, required 1", cpu_start0); end
        checks++;
        if (q0.size() != 0) begin errors++; $display("FAIL ovf_pending got %0d, required 0", q0.size()); end
        $display("test_overflow done");
    endtask

    task automatic test_toggle();
        load_req1 = 1'b1; tick(); load_req1 = 1'b0;
        exp_addr1 = 0;
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, 16'(16'hB000 + i), (i == 3));
            if (i < 3) begin
                // Idle cycle: s_last without s_valid and a stray load_req.
                s_valid = 1'b0; s_last = 1'b1; s_data = 16'hFFFF;
                load_req1 = (i == 1);
                tick();
                s_last = 1'b0; load_req1 = 1'b0;
            end
        end
        tick();
        checks++;
        if (cpu_start1 !== 1'b1) begin errors++; $display("FAIL toggle_run got %b, required 1", cpu_start1); end
        checks++;
        if (word_count1 !== 9'd4) begin errors++; $display("FAIL toggle_count got %0d, required 4", word_count1); end
        checks++;
        if (q1.size() != 0) begin errors++; $display("FAIL toggle_pending got %0d, required 0", q1.size()); end
        $display("test_toggle done");
    endtask

    task automatic test_reload();
        int c;
        checks++;
        if (cpu_start0 !== 1'b1) begin errors++; $display("FAIL reload_pre got %b, required 1", cpu_start0); end
        load_req0 = 1'b1; tick(); load_req0 = 1'b0;
        exp_addr0 = 0;
        checks++;
        if (cpu_start0 !== 1'b0 || cpu_enable0 !== 1'b0 || s_ready0 !== 1'b1) begin
            errors++; $display("FAIL reload_stop got start=%b en=%b rdy=%b, required 0 0 1", cpu_start0, cpu_enable0, s_ready0);
        end
        checks++;
        if (word_count0 !== 9'd0 || overflow0 !== 1'b0) begin
            errors++; $display("FAIL reload_clear got cnt=%0d ovf=%b, required 0 0", word_count0, overflow0);
        end
        c = cyc;
        beat(1'b0, 16'hBEEF, 1'b1);
        for (int a = 1; a <= 255; a++) exp_wr(1'b0, a, 16'h0000, c + 1 + a);
        while (cyc < c + 257) tick();
        checks++;
        if (cpu_start0 !== 1'b1 || word_count0 !== 9'd1) begin
            errors++; $display("FAIL reload_run got start=%b cnt=%0d, required 1 1", cpu_start0, word_count0);
        end
        checks++;
        if (q0.size() != 0) begin errors++; $display("FAIL reload_pending got %0d, required 0", q0.size()); end
        $display("test_reload done");
    endtask

    task automatic test_reset_mid_load();
        logic [37:0] v0, v1;
        load_req1 = 1'b1; tick(); load_req1 = 1'b0;
        exp_addr1 = 0;
        beat(1'b1, 16'hA001, 1'b0);
        beat(1'b1, 16'hA002, 1'b0);
        // Third beat offered but reset lands before it can be taken.
        s_valid = 1'b1; s_data = 16'hA003; s_last = 1'b0;
        @(negedge clock);
        #1 reset = 1'b0;
        #1;
        v0 = {s_ready0, i_we0, i_addr0, i_data0, cpu_start0, cpu_enable0, word_count0, overflow0};
        v1 = {s_ready1, i_we1, i_addr1, i_data1, cpu_start1, cpu_enable1, word_count1, overflow1};
        checks++;
        if (v1 !== 38'd0) begin errors++; $display("FAIL midreset_outs1 got %h, required 0", v1); end
        checks++;
        if (v0 !== 38'd0) begin errors++; $display("FAIL midreset_outs0 got %h, required 0", v0); end
        checks++;
        if (q1.size() != 0) begin errors++; $display("FAIL midreset_pending got %0d, required 0", q1.size()); end
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        v1 = {s_ready1, i_we1, i_addr1, i_data1, cpu_start1, cpu_enable1, word_count1, overflow1};
        checks++;
        if (v1 !== 38'd0) begin errors++; $display("FAIL midreset_idle1 got %h, required 0", v1); end
        s_valid = 1'b0;
        load_req1 = 1'b1; tick(); load_req1 = 1'b0;
        exp_addr1 = 0;
        beat(1'b1, 16'hC0DE, 1'b1);
        tick();
        checks++;
        if (cpu_start1 !== 1'b1 || word_count1 !== 9'd1) begin
            errors++; $display("FAIL midreset_reload got start=%b cnt=%0d, required 1 1", cpu_start1, word_count1);
        end
        checks++;
        if (q1.size() != 0 || q0.size() != 0) begin
            errors++; $display("FAIL final_pending got %0d/%0d, required 0/0", q0.size(), q1.size());
        end
        $display("test_reset_mid_load done");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_no_fill();
        test_overflow();
        test_toggle();
        test_reload();
        test_reset_mid_load();
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
